counter_ctrl: RTL

Sequencing controller for the codebase's N-bit up/down counter datapath. It owns the count register and runs it under a four-state FSM in one of three modes: one-shot, auto-reload or ping-pong. It latches a configuration on `start` and reports progress through `busy`, `done` and `wrap`. It sits between a host/control FSM and any logic that consumes `count`.

---
 rtl/counter_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// Sequencing controller for an up/down counter: one-shot, auto-reload and
// ping-pong runs under a four-state FSM, with busy/done/wrap progress flags.
module counter_ctrl #(
    parameter int unsigned N_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic               hold,
    input  logic [1:0]         mode,
    input  logic               up_dn,
    input  logic [N_WIDTH-1:0] limit,
    output logic [N_WIDTH-1:0] count,
    output logic               busy,
    output logic               done,
    output logic               wrap,
    output logic               dir
);

    localparam logic [N_WIDTH-1:0] ONE         = N_WIDTH'(1);
    localparam logic [1:0]         MODE_RELOAD = 2'b01;
    localparam logic [1:0]         MODE_PING   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [N_WIDTH-1:0] count_q, count_d;
    logic [N_WIDTH-1:0] limit_q, limit_d;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;

    logic [N_WIDTH-1:0] terminal_c;
    logic               at_term_c;
    logic               oneshot_c;
    logic [N_WIDTH-1:0] step_c;
    logic [N_WIDTH-1:0] reload_c;
    logic [N_WIDTH-1:0] bounce_c;

    // Datapath helpers derived from the latched run configuration
    assign terminal_c = dir_q ? limit_q : '0;
    assign at_term_c  = (count_q == terminal_c);
    assign oneshot_c  = (mode_q != MODE_RELOAD) && (mode_q != MODE_PING);
    assign step_c     = dir_q ? (count_q + ONE) : (count_q - ONE);
    assign reload_c   = dir_q ? '0 : limit_q;
    // Ping-pong turnaround steps one in the reversed direction; limit 0 pins at 0
    assign bounce_c   = (limit_q == '0) ? '0
                      : (dir_q ? (count_q - ONE) : (count_q + ONE));

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state logic; halt outranks every other request
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (hold) begin
                    state_d = S_HOLD;
                end else if (at_term_c && oneshot_c) begin
                    state_d = S_DONE;
                end
            end
            S_HOLD: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for count, direction, config latch and pulses
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        busy_d  = (state_d == S_RUN) || (state_d == S_HOLD);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (halt) begin
                    count_d = '0;
                end else if (start) begin
                    limit_d = limit;
                    mode_d  = mode;
                    dir_d   = up_dn;
                    count_d = up_dn ? '0 : limit;
                end
            end
            S_RUN: begin
                if (halt) begin
                    count_d = '0;
                end else if (!hold) begin
                    if (!at_term_c) begin
                        count_d = step_c;
                    end else if (mode_q == MODE_RELOAD) begin
                        count_d = reload_c;
                        wrap_d  = 1'b1;
                    end else if (mode_q == MODE_PING) begin
                        count_d = bounce_c;
                        dir_d   = ~dir_q;
                        wrap_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (halt) begin
                    count_d = '0;
                end
            end
            default: count_d = '0;
        endcase
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign dir   = dir_q;

endmodule
